// File: rtl/cpu_stim_mem.sv
// CPU environment block: streams host-loaded instructions into the core and serves its 256x16 data RAM.
// Optional host backdoor RAM port is compiled in with `define CPU_STIM_BACKDOOR_EN.
module cpu_stim_mem #(
  parameter int         IB_DEPTH  = 16,
  parameter int         IB_AW     = 4,
  parameter logic [4:0] NOP_OP    = 5'b00000,
  parameter logic [4:0] HALT_OP   = 5'b00001,
  parameter int         DRAIN_CYC = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        underflow,
  output logic        cpu_enable,
  output logic        cpu_start,
  output logic [15:0] cpu_i_datain,
  input  logic [7:0]  cpu_d_addr,
  input  logic [15:0] cpu_d_dataout,
  input  logic        cpu_d_we,
  output logic [15:0] cpu_d_datain
`ifdef CPU_STIM_BACKDOOR_EN
  ,
  input  logic [7:0]  host_addr,
  input  logic        host_we,
  input  logic [15:0] host_wdata,
  output logic [15:0] host_rdata
`endif
);

  localparam logic [15:0] NOP_WORD  = {NOP_OP, 11'b0};
  localparam logic [15:0] HALT_WORD = {HALT_OP, 11'b0};
  localparam int          DW        = $clog2(DRAIN_CYC) + 1;
  localparam logic [IB_AW:0] FULL_CNT = (IB_AW+1)'(IB_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       ib_mem [IB_DEPTH];
  logic [IB_AW-1:0]  wr_ptr, rd_ptr;
  logic [IB_AW:0]    count;
  logic [DW-1:0]     drain_cnt;
  logic              go_pend;
  logic              ready_en;
  logic              empty, full, push, pop, flush, go_eff, drain_last;
  logic [15:0]       head;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign head       = ib_mem[rd_ptr];
  assign load_ready = ready_en && (state == S_IDLE) && !full;
  assign push       = load_valid && load_ready;
  assign pop        = (state == S_STREAM) && !empty;
  assign drain_last = (state == S_DRAIN) && (drain_cnt == '0);
  assign flush      = drain_last;
  assign go_eff     = go || go_pend;

  assign busy       = (state == S_START) || (state == S_STREAM) || (state == S_DRAIN);
  assign cpu_enable = busy;
  assign cpu_start  = (state == S_START);

  // Instruction buffer storage (data path, not reset)
  always_ff @(posedge clock) begin
    if (push) ib_mem[wr_ptr] <= load_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (go_eff && !empty) state_nxt = S_START;
      S_START:  state_nxt = S_STREAM;
      S_STREAM: if (empty || head[15:11] == HALT_OP) state_nxt = S_DRAIN;
      S_DRAIN:  if (drain_cnt == '0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      drain_cnt    <= '0;
      cpu_i_datain <= NOP_WORD;
      underflow    <= 1'b0;
      done         <= 1'b0;
      go_pend      <= 1'b0;
      ready_en     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      // A go that coincides with the first load is carried one cycle so it sees the word.
      go_pend  <= (state == S_IDLE) && go && empty && push;
      done     <= drain_last || ((state == S_IDLE) && go_eff && empty && !push);

      if (state == S_IDLE && go_eff) underflow <= 1'b0;
      else if (state == S_STREAM && empty) underflow <= 1'b1;

      if (state == S_STREAM && state_nxt == S_DRAIN) drain_cnt <= DW'(DRAIN_CYC - 1);
      else if (state == S_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;

      unique case (state)
        S_STREAM: cpu_i_datain <= empty ? HALT_WORD : head;
        S_DRAIN:  if (drain_cnt == '0) cpu_i_datain <= NOP_WORD;
        default:  cpu_i_datain <= NOP_WORD;
      endcase
    end
  end

  // Data RAM: CPU write port always active; a same-cycle CPU write overrides the host.
  logic [15:0] mem [256];

`ifdef CPU_STIM_BACKDOOR_EN
  logic host_ok;
  assign host_ok = (state == S_IDLE) || (state == S_DONE);

  always_ff @(posedge clock) begin
    if (host_ok && host_we && !(cpu_d_we && cpu_d_addr == host_addr)) mem[host_addr] <= host_wdata;
    if (cpu_d_we) mem[cpu_d_addr] <= cpu_d_dataout;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) host_rdata <= '0;
    else if (host_ok) host_rdata <= mem[host_addr];
  end
`else
  always_ff @(posedge clock) begin
    if (cpu_d_we) mem[cpu_d_addr] <= cpu_d_dataout;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cpu_d_datain <= '0;
    else        cpu_d_datain <= mem[cpu_d_addr];
  end

endmodule

// File: tb/tb_cpu_stim_mem.sv
// Randomised self-checking bench for cpu_stim_mem (default build, no backdoor),
// comparing against a queue-based model of the instruction stream and an array model of the RAM.
module tb_cpu_stim_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        go;
  logic        busy, done, underflow;
  logic        cpu_enable, cpu_start;
  logic [15:0] cpu_i_datain;
  logic [7:0]  cpu_d_addr;
  logic [15:0] cpu_d_dataout;
  logic        cpu_d_we;
  logic [15:0] cpu_d_datain;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[$];
  logic [15:0] mem_model [8];

  localparam logic [15:0] HALT_W = 16'h0800;

  cpu_stim_mem dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .go(go), .busy(busy), .done(done), .underflow(underflow),
    .cpu_enable(cpu_enable), .cpu_start(cpu_start), .cpu_i_datain(cpu_i_datain),
    .cpu_d_addr(cpu_d_addr), .cpu_d_dataout(cpu_d_dataout), .cpu_d_we(cpu_d_we),
    .cpu_d_datain(cpu_d_datain)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] rand_word(input bit allow_halt);
    logic [15:0] w;
    w = 16'($urandom);
    if (!allow_halt && w[15:11] == 5'b00001) w[15:11] = 5'b00010;
    return w;
  endfunction

  task automatic load_words(input int n, input int halt_pos);
    logic [15:0] w;
    logic exp_rdy;
    for (int i = 0; i < n; i++) begin
      w = rand_word(0);
      if (i == halt_pos) w[15:11] = 5'b00001;
      load_valid = 1'b1;
      load_data  = w;
      exp_rdy = (q.size() < 16);
      checks++;
      if (load_ready !== exp_rdy) begin
        errors++;
        $display("FAIL load_ready word %0d: got %b expected %b", i, load_ready, exp_rdy);
      end
      if (exp_rdy) q.push_back(w);
      tick();
    end
    load_valid = 1'b0;
  endtask

  // Expected run: START, one NOP cycle, words up to HALT, HALT shown 4 cycles, DONE.
  task automatic run_and_check(input string name, input bit pre_started);
    logic [15:0] exp_d[$];
    logic exp_uf;
    exp_uf = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i][15:11] == 5'b00001) begin
        for (int k = 0; k < 4; k++) exp_d.push_back(q[i]);
        exp_uf = 1'b0;
        break;
      end
      exp_d.push_back(q[i]);
    end
    if (exp_uf) for (int k = 0; k < 4; k++) exp_d.push_back(HALT_W);

    if (!pre_started) begin
      go = 1'b1;
      tick();
      go = 1'b0;
    end
    checks++;
    if ({cpu_enable, cpu_start, busy, done, cpu_i_datain} !== {4'b1110, 16'h0000}) begin
      errors++;
      $display("FAIL %s start: got en/st/bz/dn=%b%b%b%b d=%h expected 1110 d=0000",
               name, cpu_enable, cpu_start, busy, done, cpu_i_datain);
    end
    tick();
    checks++;
    if ({cpu_enable, cpu_start, busy, done, cpu_i_datain} !== {4'b1010, 16'h0000}) begin
      errors++;
      $display("FAIL %s first stream: got en/st/bz/dn=%b%b%b%b d=%h expected 1010 d=0000",
               name, cpu_enable, cpu_start, busy, done, cpu_i_datain);
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      tick();
      checks++;
      if ({cpu_enable, cpu_start, busy, done, cpu_i_datain} !== {4'b1010, exp_d[i]}) begin
        errors++;
        $display("FAIL %s word %0d: got en/st/bz/dn=%b%b%b%b d=%h expected 1010 d=%h",
                 name, i, cpu_enable, cpu_start, busy, done, cpu_i_datain, exp_d[i]);
      end
    end
    tick();
    checks++;
    if ({cpu_enable, cpu_start, busy, done, underflow, cpu_i_datain} !== {4'b0001, exp_uf, 16'h0000}) begin
      errors++;
      $display("FAIL %s done: got en/st/bz/dn=%b%b%b%b uf=%b d=%h expected 0001 uf=%b d=0000",
               name, cpu_enable, cpu_start, busy, done, underflow, cpu_i_datain, exp_uf);
    end
    tick();
    checks++;
    if ({done, busy, load_ready, underflow} !== {3'b001, exp_uf}) begin
      errors++;
      $display("FAIL %s idle: got dn/bz/rdy/uf=%b%b%b%b expected 001%b",
               name, done, busy, load_ready, underflow, exp_uf);
    end
    q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b1; load_data = 16'hFFFF; go = 1'b0;
    cpu_d_we = 1'b0; cpu_d_addr = 8'h00; cpu_d_dataout = 16'h0000;
    tick(); tick();
    checks++;
    if ({load_ready, busy, done, underflow, cpu_enable, cpu_start, cpu_i_datain, cpu_d_datain} !== 38'd0) begin
      errors++;
      $display("FAIL reset outputs: got rdy=%b bz=%b dn=%b uf=%b en=%b st=%b i=%h d=%h expected all 0",
               load_ready, busy, done, underflow, cpu_enable, cpu_start, cpu_i_datain, cpu_d_datain);
    end
    #3 reset = 1'b1;
    tick();
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset release ready: got %b expected 1", load_ready);
    end
    load_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] words [4];
    words = '{16'h4A22, 16'h0000, 16'h0000, 16'h0800};
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = words[i]; q.push_back(words[i]);
      tick();
    end
    load_valid = 1'b0;
    run_and_check("basic", 1'b0);
  endtask

  task automatic test_underflow();
    load_valid = 1'b1; load_data = 16'h4A22; q.push_back(16'h4A22);
    tick();
    load_valid = 1'b0;
    run_and_check("underflow", 1'b0);
  endtask

  task automatic test_full();
    load_words(17, -1);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL full ready: got %b expected 0", load_ready);
    end
    run_and_check("full", 1'b0);
  endtask

  task automatic test_wrap();
    load_words(8, -1);
    run_and_check("wrap8", 1'b0);
    load_words(16, -1);
    run_and_check("wrap16", 1'b0);
  endtask

  task automatic test_load_go_same();
    load_valid = 1'b1; load_data = 16'h1234; go = 1'b1; q.push_back(16'h1234);
    tick();
    load_valid = 1'b0; go = 1'b0;
    checks++;
    if ({done, cpu_start, busy} !== 3'b000) begin
      errors++;
      $display("FAIL load_go same cycle: got dn/st/bz=%b%b%b expected 000", done, cpu_start, busy);
    end
    tick();
    run_and_check("load_go", 1'b1);
  endtask

  task automatic test_random();
    int n, h;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 16);
      h = $urandom_range(0, n);
      load_words(n, h);
      run_and_check("random", 1'b0);
    end
  endtask

  task automatic test_ram();
    logic [2:0]  a;
    logic        we;
    logic [15:0] d, exp;
    cpu_d_we = 1'b1; cpu_d_addr = 8'h05; cpu_d_dataout = 16'h2220;
    tick();
    cpu_d_we = 1'b0;
    tick();
    checks++;
    if (cpu_d_datain !== 16'h2220) begin
      errors++;
      $display("FAIL ram read: got %h expected 2220", cpu_d_datain);
    end
    cpu_d_we = 1'b1; cpu_d_dataout = 16'h1111;
    tick();
    cpu_d_we = 1'b0;
    checks++;
    if (cpu_d_datain !== 16'h2220) begin
      errors++;
      $display("FAIL ram read-during-write: got %h expected 2220", cpu_d_datain);
    end
    tick();
    checks++;
    if (cpu_d_datain !== 16'h1111) begin
      errors++;
      $display("FAIL ram after write: got %h expected 1111", cpu_d_datain);
    end
    for (int i = 0; i < 8; i++) begin
      mem_model[i] = 16'($urandom);
      cpu_d_we = 1'b1; cpu_d_addr = 8'(i); cpu_d_dataout = mem_model[i];
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      a  = 3'($urandom_range(0, 7));
      we = 1'($urandom);
      d  = 16'($urandom);
      cpu_d_we = we; cpu_d_addr = {5'b0, a}; cpu_d_dataout = d;
      exp = mem_model[a];
      tick();
      checks++;
      if (cpu_d_datain !== exp) begin
        errors++;
        $display("FAIL ram random %0d addr %0d: got %h expected %h", i, a, cpu_d_datain, exp);
      end
      if (we) mem_model[a] = d;
    end
    cpu_d_we = 1'b0;
  endtask

  task automatic test_reset_midrun();
    load_words(6, -1);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, cpu_enable, cpu_start, load_ready, done, cpu_i_datain} !== 21'd0) begin
      errors++;
      $display("FAIL midrun reset: got bz=%b en=%b st=%b rdy=%b dn=%b i=%h expected all 0",
               busy, cpu_enable, cpu_start, load_ready, done, cpu_i_datain);
    end
    q.delete();
    #2 reset = 1'b1;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++;
    if ({done, cpu_start, busy} !== 3'b100) begin
      errors++;
      $display("FAIL empty go after reset: got dn/st/bz=%b%b%b expected 100", done, cpu_start, busy);
    end
    tick();
    checks++;
    if ({done, cpu_start, busy} !== 3'b000) begin
      errors++;
      $display("FAIL empty go pulse end: got dn/st/bz=%b%b%b expected 000", done, cpu_start, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_full();
    test_wrap();
    test_load_go_same();
    test_random();
    test_ram();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
